// File: rtl/ahb_master_arb.sv
// ahb_master_arb: 2-to-1 AHB-lite initiator-side arbiter.
//   Two AHB-lite masters (port 0, port 1) share one downstream AHB-lite
//   master interface. Each port captures its address phase into a holding
//   slot and stalls its master through s_hready_x. The stall lasts until the
//   held transfer has been issued downstream and its data phase completes.
//   Data-phase routing follows the registered data-phase owner dp_own.
// Build option: define AHB_ARB_RR_EN for round-robin arbitration. The
//   default build uses fixed priority, where port 0 always wins.
// Ports:
//   clk, rstn                      clock, async active-low reset
//   s_*_0 / s_*_1                  upstream AHB-lite slave-side ports
//   m_haddr/htrans/hwrite/hsize    downstream address phase
//   m_hwdata                       downstream write data (owner's)
//   m_hready/m_hrdata/m_hresp      downstream response
module ahb_master_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] s_haddr_0,
  input  logic [ADDR_W-1:0] s_haddr_1,
  input  logic [1:0]        s_htrans_0,
  input  logic [1:0]        s_htrans_1,
  input  logic              s_hwrite_0,
  input  logic              s_hwrite_1,
  input  logic [2:0]        s_hsize_0,
  input  logic [2:0]        s_hsize_1,
  input  logic [DATA_W-1:0] s_hwdata_0,
  input  logic [DATA_W-1:0] s_hwdata_1,
  output logic              s_hready_0,
  output logic              s_hready_1,
  output logic [DATA_W-1:0] s_hrdata_0,
  output logic [DATA_W-1:0] s_hrdata_1,
  output logic              s_hresp_0,
  output logic              s_hresp_1,
  output logic [ADDR_W-1:0] m_haddr,
  output logic [1:0]        m_htrans,
  output logic              m_hwrite,
  output logic [2:0]        m_hsize,
  output logic [DATA_W-1:0] m_hwdata,
  input  logic              m_hready,
  input  logic [DATA_W-1:0] m_hrdata,
  input  logic              m_hresp
);

  typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_P0 = 2'b01, OWN_P1 = 2'b10} own_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic              pend_0, pend_1, pend_0_n, pend_1_n;
  logic [ADDR_W-1:0] hold_addr_0, hold_addr_1;
  logic              hold_write_0, hold_write_1;
  logic [2:0]        hold_size_0, hold_size_1;
  own_e              dp_own, dp_own_n, ag_q, ag_q_n, ag, arb;
  logic              aph_lock, aph_lock_n;
  logic              last, last_n;     // 0: port 0, 1: port 1
  logic              cap_0, cap_1, acc_0, acc_1;
  logic              unused_sig;

  // Capture only NONSEQ/SEQ; IDLE/BUSY see a zero-wait OKAY.
  assign cap_0 = s_hready_0 & s_htrans_0[1];
  assign cap_1 = s_hready_1 & s_htrans_1[1];
  assign acc_0 = (ag == OWN_P0) & m_hready;
  assign acc_1 = (ag == OWN_P1) & m_hready;

`ifdef AHB_ARB_RR_EN
  always_comb begin
    arb = OWN_NONE;
    if (pend_0 && pend_1) arb = last ? OWN_P0 : OWN_P1;
    else if (pend_0)      arb = OWN_P0;
    else if (pend_1)      arb = OWN_P1;
  end
  assign unused_sig = ^{s_htrans_0[0], s_htrans_1[0]};
`else
  always_comb begin
    arb = OWN_NONE;
    if (pend_0)      arb = OWN_P0;
    else if (pend_1) arb = OWN_P1;
  end
  // last is still tracked but does not influence fixed priority.
  assign unused_sig = ^{s_htrans_0[0], s_htrans_1[0], last};
`endif

  // A stalled address phase keeps its grant so the downstream address
  // stays stable even if the other port's request would now win.
  assign ag = aph_lock ? ag_q : arb;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_0   <= 1'b0;
      pend_1   <= 1'b0;
      dp_own   <= OWN_NONE;
      aph_lock <= 1'b0;
      ag_q     <= OWN_NONE;
      last     <= 1'b1;
    end else begin
      pend_0   <= pend_0_n;
      pend_1   <= pend_1_n;
      dp_own   <= dp_own_n;
      aph_lock <= aph_lock_n;
      ag_q     <= ag_q_n;
      last     <= last_n;
    end
  end

  // Holding slots load only on capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_addr_0  <= '0;
      hold_write_0 <= 1'b0;
      hold_size_0  <= '0;
      hold_addr_1  <= '0;
      hold_write_1 <= 1'b0;
      hold_size_1  <= '0;
    end else begin
      if (cap_0) begin
        hold_addr_0  <= s_haddr_0;
        hold_write_0 <= s_hwrite_0;
        hold_size_0  <= s_hsize_0;
      end
      if (cap_1) begin
        hold_addr_1  <= s_haddr_1;
        hold_write_1 <= s_hwrite_1;
        hold_size_1  <= s_hsize_1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    pend_0_n   = cap_0 | (pend_0 & ~acc_0);
    pend_1_n   = cap_1 | (pend_1 & ~acc_1);
    dp_own_n   = m_hready ? ag : dp_own;
    aph_lock_n = aph_lock;
    ag_q_n     = ag_q;
    if (m_hready) begin
      aph_lock_n = 1'b0;
    end else if (ag != OWN_NONE) begin
      aph_lock_n = 1'b1;
      ag_q_n     = ag;
    end
    last_n = last;
    if (acc_0)      last_n = 1'b0;
    else if (acc_1) last_n = 1'b1;
  end

  // Output logic
  always_comb begin
    m_htrans = HTRANS_IDLE;
    m_haddr  = '0;
    m_hwrite = 1'b0;
    m_hsize  = '0;
    case (ag)
      OWN_P0: begin
        m_htrans = HTRANS_NONSEQ;
        m_haddr  = hold_addr_0;
        m_hwrite = hold_write_0;
        m_hsize  = hold_size_0;
      end
      OWN_P1: begin
        m_htrans = HTRANS_NONSEQ;
        m_haddr  = hold_addr_1;
        m_hwrite = hold_write_1;
        m_hsize  = hold_size_1;
      end
      default: ;
    endcase
  end

  assign s_hready_0 = (dp_own == OWN_P0) ? m_hready : ~pend_0;
  assign s_hready_1 = (dp_own == OWN_P1) ? m_hready : ~pend_1;
  assign s_hresp_0  = (dp_own == OWN_P0) ? m_hresp : 1'b0;
  assign s_hresp_1  = (dp_own == OWN_P1) ? m_hresp : 1'b0;
  assign s_hrdata_0 = m_hrdata;
  assign s_hrdata_1 = m_hrdata;
  assign m_hwdata   = (dp_own == OWN_P1) ? s_hwdata_1 : s_hwdata_0;

endmodule

// File: tb/tb_ahb_master_arb.sv
// Directed bench for ahb_master_arb. The inputs are driven 1 ns after each
// rising edge, and the outputs are checked at the following falling edge.
module tb_ahb_master_arb;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
`ifdef AHB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic [ADDR_W-1:0] s_haddr_0, s_haddr_1;
  logic [1:0]        s_htrans_0, s_htrans_1;
  logic              s_hwrite_0, s_hwrite_1;
  logic [2:0]        s_hsize_0, s_hsize_1;
  logic [DATA_W-1:0] s_hwdata_0, s_hwdata_1;
  logic              s_hready_0, s_hready_1;
  logic [DATA_W-1:0] s_hrdata_0, s_hrdata_1;
  logic              s_hresp_0, s_hresp_1;
  logic [ADDR_W-1:0] m_haddr;
  logic [1:0]        m_htrans;
  logic              m_hwrite;
  logic [2:0]        m_hsize;
  logic [DATA_W-1:0] m_hwdata;
  logic              m_hready;
  logic [DATA_W-1:0] m_hrdata;
  logic              m_hresp;

  int checks = 0;
  int errors = 0;
  logic [31:0] first_addr, second_addr, first_wd, second_wd;

  always #5 clk = ~clk;

  ahb_master_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rstn(rstn),
    .s_haddr_0(s_haddr_0), .s_haddr_1(s_haddr_1),
    .s_htrans_0(s_htrans_0), .s_htrans_1(s_htrans_1),
    .s_hwrite_0(s_hwrite_0), .s_hwrite_1(s_hwrite_1),
    .s_hsize_0(s_hsize_0), .s_hsize_1(s_hsize_1),
    .s_hwdata_0(s_hwdata_0), .s_hwdata_1(s_hwdata_1),
    .s_hready_0(s_hready_0), .s_hready_1(s_hready_1),
    .s_hrdata_0(s_hrdata_0), .s_hrdata_1(s_hrdata_1),
    .s_hresp_0(s_hresp_0), .s_hresp_1(s_hresp_1),
    .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite),
    .m_hsize(m_hsize), .m_hwdata(m_hwdata),
    .m_hready(m_hready), .m_hrdata(m_hrdata), .m_hresp(m_hresp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    s_haddr_0 = '0; s_haddr_1 = '0; s_htrans_0 = 2'b00; s_htrans_1 = 2'b00;
    s_hwrite_0 = 1'b0; s_hwrite_1 = 1'b0; s_hsize_0 = 3'd2; s_hsize_1 = 3'd2;
    s_hwdata_0 = 32'hAAAA5555; s_hwdata_1 = 32'h5555AAAA;
    m_hready = 1'b1; m_hrdata = '0; m_hresp = 1'b0;

    // Reset state
    cyc; cyc; smp;
    chk("rst_htrans", m_htrans, 2'b00);
    chk("rst_hready0", s_hready_0, 1'b1);
    chk("rst_hready1", s_hready_1, 1'b1);
    chk("rst_hresp0", s_hresp_0, 1'b0);
    chk("rst_hresp1", s_hresp_1, 1'b0);
    cyc; rstn = 1'b1;

    // Simultaneous writes: both modes grant port 0 first (last = P1 at reset)
    cyc;
    s_htrans_0 = 2'b10; s_haddr_0 = 32'h2000; s_hwrite_0 = 1'b1;
    s_htrans_1 = 2'b10; s_haddr_1 = 32'h3000; s_hwrite_1 = 1'b1;
    cyc;
    s_htrans_0 = 2'b00; s_htrans_1 = 2'b00;
    smp;
    chk("p1_haddr_a", m_haddr, 32'h2000);
    chk("p1_htrans_a", m_htrans, 2'b10);
    chk("p1_hwrite_a", m_hwrite, 1'b1);
    chk("p1_hready0_a", s_hready_0, 1'b0);
    chk("p1_hready1_a", s_hready_1, 1'b0);
    cyc; smp;
    chk("p1_haddr_b", m_haddr, 32'h3000);
    chk("p1_hwdata_b", m_hwdata, 32'hAAAA5555);
    chk("p1_hready0_b", s_hready_0, 1'b1);
    chk("p1_hready1_b", s_hready_1, 1'b0);
    cyc; smp;
    chk("p1_htrans_c", m_htrans, 2'b00);
    chk("p1_hwdata_c", m_hwdata, 32'h5555AAAA);
    chk("p1_hready1_c", s_hready_1, 1'b1);
    cyc;

    // Single read on port 0
    s_htrans_0 = 2'b10; s_haddr_0 = 32'h1000; s_hwrite_0 = 1'b0; s_hsize_0 = 3'd2;
    cyc;
    s_htrans_0 = 2'b00;
    smp;
    chk("rd_htrans", m_htrans, 2'b10);
    chk("rd_haddr", m_haddr, 32'h1000);
    chk("rd_hsize", m_hsize, 3'd2);
    chk("rd_hwrite", m_hwrite, 1'b0);
    chk("rd_hready0_wait", s_hready_0, 1'b0);
    cyc;
    m_hrdata = 32'hDEADBEEF;
    smp;
    chk("rd_hready0_done", s_hready_0, 1'b1);
    chk("rd_hrdata0", s_hrdata_0, 32'hDEADBEEF);
    chk("rd_htrans_idle", m_htrans, 2'b00);
    cyc;

    // Second simultaneous pair: last = P0 now, so round-robin favours port 1
    first_addr  = RR ? 32'h3100 : 32'h2100;
    second_addr = RR ? 32'h2100 : 32'h3100;
    first_wd    = RR ? 32'h5555AAAA : 32'hAAAA5555;
    second_wd   = RR ? 32'hAAAA5555 : 32'h5555AAAA;
    s_htrans_0 = 2'b10; s_haddr_0 = 32'h2100; s_hwrite_0 = 1'b1;
    s_htrans_1 = 2'b10; s_haddr_1 = 32'h3100; s_hwrite_1 = 1'b1;
    cyc;
    s_htrans_0 = 2'b00; s_htrans_1 = 2'b00;
    smp;
    chk("p2_haddr_first", m_haddr, first_addr);
    cyc; smp;
    chk("p2_haddr_second", m_haddr, second_addr);
    chk("p2_hwdata_first", m_hwdata, first_wd);
    cyc; smp;
    chk("p2_hwdata_second", m_hwdata, second_wd);
    chk("p2_htrans_idle", m_htrans, 2'b00);
    cyc;

    // Wait states on a port 1 address phase while port 0 queues up
    s_htrans_1 = 2'b10; s_haddr_1 = 32'h4000; s_hwrite_1 = 1'b0;
    cyc;
    s_htrans_1 = 2'b00;
    m_hready = 1'b0;
    s_htrans_0 = 2'b10; s_haddr_0 = 32'h5000; s_hwrite_0 = 1'b0;
    smp;
    chk("ws_haddr_w1", m_haddr, 32'h4000);
    chk("ws_htrans_w1", m_htrans, 2'b10);
    chk("ws_hready0_cap", s_hready_0, 1'b1);
    cyc;
    s_htrans_0 = 2'b00;
    smp;
    chk("ws_haddr_w2", m_haddr, 32'h4000);
    chk("ws_htrans_w2", m_htrans, 2'b10);
    chk("ws_hready1_w2", s_hready_1, 1'b0);
    chk("ws_hready0_w2", s_hready_0, 1'b0);
    cyc; smp;
    chk("ws_haddr_w3", m_haddr, 32'h4000);
    chk("ws_hready1_w3", s_hready_1, 1'b0);
    cyc;
    m_hready = 1'b1;
    smp;
    chk("ws_haddr_rel", m_haddr, 32'h4000);
    chk("ws_hready1_rel", s_hready_1, 1'b0);
    cyc;
    m_hrdata = 32'h12345678;
    smp;
    chk("ws_hready1_done", s_hready_1, 1'b1);
    chk("ws_hrdata1", s_hrdata_1, 32'h12345678);
    chk("ws_haddr_p0", m_haddr, 32'h5000);
    chk("ws_hready0_p0", s_hready_0, 1'b0);
    cyc; smp;
    chk("ws_hready0_done", s_hready_0, 1'b1);
    chk("ws_htrans_idle", m_htrans, 2'b00);
    cyc;

    // Two-cycle ERROR response on port 0
    s_htrans_0 = 2'b10; s_haddr_0 = 32'h6000;
    cyc;
    s_htrans_0 = 2'b00;
    smp;
    chk("err_haddr", m_haddr, 32'h6000);
    cyc;
    m_hready = 1'b0; m_hresp = 1'b1;
    smp;
    chk("err_hresp0_c1", s_hresp_0, 1'b1);
    chk("err_hready0_c1", s_hready_0, 1'b0);
    chk("err_hresp1_c1", s_hresp_1, 1'b0);
    cyc;
    m_hready = 1'b1;
    smp;
    chk("err_hresp0_c2", s_hresp_0, 1'b1);
    chk("err_hready0_c2", s_hready_0, 1'b1);
    chk("err_hresp1_c2", s_hresp_1, 1'b0);
    cyc;
    m_hresp = 1'b0;
    smp;
    chk("err_hresp0_after", s_hresp_0, 1'b0);

    // IDLE on port 1 is not captured; SEQ is re-issued as NONSEQ
    cyc;
    s_htrans_1 = 2'b00; s_haddr_1 = 32'h3000;
    smp;
    chk("idle_hready1", s_hready_1, 1'b1);
    cyc;
    s_htrans_1 = 2'b11; s_haddr_1 = 32'h3004;
    smp;
    chk("idle_no_issue", m_htrans, 2'b00);
    cyc;
    s_htrans_1 = 2'b00;
    smp;
    chk("seq_htrans", m_htrans, 2'b10);
    chk("seq_haddr", m_haddr, 32'h3004);
    cyc; smp;
    chk("seq_hready1_done", s_hready_1, 1'b1);
    cyc;

    // Reset while port 0 has a stalled request
    s_htrans_0 = 2'b10; s_haddr_0 = 32'h7000;
    cyc;
    s_htrans_0 = 2'b00;
    m_hready = 1'b0;
    smp;
    chk("rst_mid_issue", m_htrans, 2'b10);
    cyc;
    rstn = 1'b0;
    #1;
    chk("rst_mid_htrans", m_htrans, 2'b00);
    chk("rst_mid_hready0", s_hready_0, 1'b1);
    chk("rst_mid_hready1", s_hready_1, 1'b1);
    cyc;
    rstn = 1'b1;
    m_hready = 1'b1;
    smp;
    chk("rst_post_htrans_a", m_htrans, 2'b00);
    cyc; smp;
    chk("rst_post_htrans_b", m_htrans, 2'b00);
    chk("rst_post_hready0", s_hready_0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
